// File: rtl/fetch_align.sv
// Realigns word-aligned fetch words into single RVC or 32-bit instructions.
// Holds up to three 16-bit parcels; stale words from before a redirect are dropped by PC match.
module fetch_align #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [63:0] flush_pc,
    input  logic        fetch_valid,
    input  logic [63:0] fetch_pc,
    input  logic [31:0] fetch_data,
    output logic        fetch_ready,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_compressed,
    input  logic        out_ready
);

    logic [2:0][15:0] hw;
    logic [1:0]       count;
    logic [63:0]      head_pc;
    logic [63:0]      exp_pc;
    logic             skip_lo;

    logic        match, room, accept, fire, is_c;
    logic [1:0]  pop_n, push_n;
    logic [2:0]  rem;
    logic [47:0] pushed, remaining, keep_mask, hw_next;
    logic [63:0] head_next;
    logic        unused_flush_bit;

    assign unused_flush_bit = flush_pc[0];

    assign match       = fetch_pc[63:2] == exp_pc[63:2];
    assign room        = count <= 2'd1;
    assign fetch_ready = !flush && (room || !match);
    assign accept      = fetch_valid && fetch_ready && match;

    // Gated by count so an empty queue never claims to hold a compressed parcel.
    assign is_c           = (count != 2'd0) && (hw[0][1:0] != 2'b11);
    assign out_valid      = !flush && (count >= 2'd2 || (count == 2'd1 && is_c));
    assign out_instr      = is_c ? {16'h0, hw[0]} : {hw[1], hw[0]};
    assign out_pc         = head_pc;
    assign out_compressed = is_c;

    assign fire   = out_valid && out_ready;
    assign pop_n  = !fire ? 2'd0 : (is_c ? 2'd1 : 2'd2);
    assign push_n = !accept ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);
    assign rem    = {1'b0, count} - {1'b0, pop_n};

    // Pop by shifting down, then append pushed parcels directly behind the survivors.
    always_comb begin
        pushed = 48'h0;
        if (accept)
            pushed = skip_lo ? {32'h0, fetch_data[31:16]} : {16'h0, fetch_data};
        remaining = hw >> {pop_n, 4'b0};
        keep_mask = ~(48'hFFFF_FFFF_FFFF << {rem, 4'b0});
        hw_next   = (remaining & keep_mask) | (pushed << {rem, 4'b0});
    end

    always_comb begin
        head_next = head_pc;
        if (accept && rem == 3'd0)
            head_next = fetch_pc + (skip_lo ? 64'd2 : 64'd0);
        else if (fire)
            head_next = head_pc + (is_c ? 64'd2 : 64'd4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw      <= '0;
            count   <= 2'd0;
            head_pc <= {RESET_PC[63:1], 1'b0};
            exp_pc  <= {RESET_PC[63:2], 2'b00};
            skip_lo <= RESET_PC[1];
        end else if (flush) begin
            count   <= 2'd0;
            exp_pc  <= {flush_pc[63:2], 2'b00};
            skip_lo <= flush_pc[1];
        end else begin
            hw      <= hw_next;
            count   <= count - pop_n + push_n;
            head_pc <= head_next;
            if (accept) begin
                exp_pc  <= exp_pc + 64'd4;
                skip_lo <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: a parcel-queue model checks outputs every cycle,
// and literal instruction sequences pin both the model and the DUT.
module tb_fetch_align;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] flush_pc = 64'h0;
    logic        fetch_valid = 1'b0;
    logic [63:0] fetch_pc = 64'h0;
    logic [31:0] fetch_data = 32'h0;
    logic        fetch_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_compressed;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    fetch_align #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_data(fetch_data),
        .fetch_ready(fetch_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_instr(out_instr), .out_compressed(out_compressed), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] pc; logic [15:0] hw; } parcel_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; logic c; } fire_t;

    parcel_t     mq[$];
    fire_t       flog[$];
    logic [63:0] mexp = {RESET_PC[63:2], 2'b00};
    logic        mskip = RESET_PC[1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each queued parcel carries its own address; instructions are read off the front.
    logic        e_c, e_valid, e_fready, e_match;
    int          e_need;
    logic [31:0] e_instr;
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mexp  = {RESET_PC[63:2], 2'b00};
            mskip = RESET_PC[1];
        end else begin
            e_c      = mq.size() > 0 && mq[0].hw[1:0] != 2'b11;
            e_need   = e_c ? 1 : 2;
            e_valid  = !flush && mq.size() >= e_need;
            e_match  = fetch_pc[63:2] == mexp[63:2];
            e_fready = !flush && (mq.size() <= 1 || !e_match);
            chk("fetch_ready", 64'(fetch_ready), 64'(e_fready));
            chk("out_valid", 64'(out_valid), 64'(e_valid));
            if (e_valid) begin
                e_instr = e_c ? {16'h0, mq[0].hw} : {mq[1].hw, mq[0].hw};
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_instr", 64'(out_instr), 64'(e_instr));
                chk("out_compressed", 64'(out_compressed), 64'(e_c));
            end
            if (out_valid && out_ready)
                flog.push_back('{out_pc, out_instr, out_compressed});
            if (flush) begin
                mq.delete();
                mexp  = {flush_pc[63:2], 2'b00};
                mskip = flush_pc[1];
            end else begin
                if (e_valid && out_ready)
                    repeat (e_need) void'(mq.pop_front());
                if (fetch_valid && e_fready && e_match) begin
                    if (!mskip) mq.push_back({fetch_pc, fetch_data[15:0]});
                    mq.push_back({fetch_pc + 64'd2, fetch_data[31:16]});
                    mskip = 1'b0;
                    mexp  = mexp + 64'd4;
                end
            end
        end
    end

    task automatic send(input logic [63:0] pc, input logic [31:0] d);
        bit got = 0;
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_data  = d;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (fetch_ready) begin got = 1; break; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_timeout: word @%h never accepted", pc);
        end
        @(posedge clk); #1;
        fetch_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        fetch_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [63:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic exp_fire(input string name, input logic [63:0] pc, input logic [31:0] ins, input logic c);
        fire_t f;
        if (flog.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: no instruction, expected %h @%h", name, ins, pc);
        end else begin
            f = flog.pop_front();
            chk({name, "_pc"}, f.pc, pc);
            chk({name, "_instr"}, 64'(f.instr), 64'(ins));
            chk({name, "_c"}, 64'(f.c), 64'(c));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'h8000_0000);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_compressed", 64'(out_compressed), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);

        // Single 32-bit word, visible one cycle after acceptance
        send(64'h8000_0000, 32'h00A0_0513);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_instr", 64'(out_instr), 64'h00A0_0513);
        idle(3);
        exp_fire("t1", 64'h8000_0000, 32'h00A0_0513, 1'b0);

        // RVC-only stream
        do_flush(64'h8000_0000);
        send(64'h8000_0000, 32'h0505_4501);
        send(64'h8000_0004, 32'h0001_0001);
        idle(6);
        exp_fire("t2a", 64'h8000_0000, 32'h0000_4501, 1'b1);
        exp_fire("t2b", 64'h8000_0002, 32'h0000_0505, 1'b1);
        exp_fire("t2c", 64'h8000_0004, 32'h0000_0001, 1'b1);
        exp_fire("t2d", 64'h8000_0006, 32'h0000_0001, 1'b1);

        // Straddling 32-bit instruction; trailing zero parcel decodes as compressed
        do_flush(64'h100);
        send(64'h100, 32'h0513_4501);
        send(64'h104, 32'h0000_00A0);
        idle(6);
        exp_fire("t3a", 64'h100, 32'h0000_4501, 1'b1);
        exp_fire("t3b", 64'h102, 32'h00A0_0513, 1'b0);
        exp_fire("t3c", 64'h106, 32'h0000_0000, 1'b1);

        // Redirect to a halfword target with stale words still arriving
        do_flush(64'h206);
        send(64'h110, 32'hDEAD_BEEF);
        send(64'h114, 32'hCAFE_F00D);
        chk("stale_no_out", 64'(out_valid), 64'd0);
        send(64'h204, 32'h1234_4581);
        idle(4);
        exp_fire("t4", 64'h206, 32'h0000_1234, 1'b1);
        chk("t4_only_one", 64'(flog.size()), 64'd0);

        // Backpressure with three parcels queued
        out_ready = 1'b0;
        do_flush(64'h302);
        send(64'h300, 32'h4501_FFFF);
        send(64'h304, 32'h00A0_0513);
        fetch_valid = 1'b1;
        fetch_pc    = 64'h308;
        fetch_data  = 32'h0001_0001;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_pc", out_pc, 64'h302);
        chk("bp_instr", 64'(out_instr), 64'h4501);
        chk("bp_fetch_ready", 64'(fetch_ready), 64'd0);
        out_ready = 1'b1;
        send(64'h308, 32'h0001_0001);
        idle(6);
        exp_fire("t5a", 64'h302, 32'h0000_4501, 1'b1);
        exp_fire("t5b", 64'h304, 32'h00A0_0513, 1'b0);
        exp_fire("t5c", 64'h308, 32'h0000_0001, 1'b1);
        exp_fire("t5d", 64'h30A, 32'h0000_0001, 1'b1);

        // Address wrap across 2^64
        do_flush(64'hFFFF_FFFF_FFFF_FFFE);
        send(64'hFFFF_FFFF_FFFF_FFFC, 32'h0513_FFFF);
        send(64'h0, 32'h4501_00A0);
        idle(5);
        exp_fire("t6a", 64'hFFFF_FFFF_FFFF_FFFE, 32'h00A0_0513, 1'b0);
        exp_fire("t6b", 64'h2, 32'h0000_4501, 1'b1);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        send(64'h4, 32'h00A0_0513);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_pc", out_pc, 64'h8000_0000);
        chk("mid_rst_ready", 64'(fetch_ready), 64'd1);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(64'h8000_0000, 32'h0050_0093);
        idle(3);
        exp_fire("t7", 64'h8000_0000, 32'h0050_0093, 1'b0);
        chk("log_empty", 64'(flog.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
